// File: rtl/pose_match_scorer_pkg.sv
// Shared types and defaults for the pose match scorer: FSM state encoding,
// counter/divider width defaults and the window span helper.
package pose_match_pkg;

  localparam int COUNT_W_DEFAULT = 17;
  localparam int DIV_W_DEFAULT   = 24;
  localparam int SCORE_MAX       = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // True when lo <= pos < lo+len, all 12-bit unsigned.
  function automatic logic in_span(input logic [11:0] pos,
                                   input logic [11:0] lo,
                                   input logic [11:0] len);
    logic [11:0] hi;
    hi = lo + len;
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/pose_match_scorer_divider.sv
// Restoring divider, one quotient bit per clock MSB first; loads on start and
// finishes W edges later. Division by zero yields a zero quotient.
module seq_restoring_divider
  import pose_match_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     rem_reg;
  logic [W-1:0]     quo_reg;
  logic [W-1:0]     dsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             active_reg;
  logic             zero_reg;
  logic             done_reg;

  logic [W:0] trial;
  logic [W:0] diff;
  logic       fits;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  always_comb begin
    trial = {rem_reg, quo_reg[W-1]};
    diff  = trial - {1'b0, dsr_reg};
    fits  = (trial >= {1'b0, dsr_reg});
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg    <= '0;
      quo_reg    <= '0;
      dsr_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      zero_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (start) begin
      rem_reg    <= '0;
      quo_reg    <= dividend;
      dsr_reg    <= divisor;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
      zero_reg   <= (divisor == '0);
      done_reg   <= 1'b0;
    end else if (active_reg) begin
      rem_reg <= fits ? diff[W-1:0] : trial[W-1:0];
      quo_reg <= {quo_reg[W-2:0], fits};
      if (cnt_reg == CNT_W'(W - 1)) begin
        active_reg <= 1'b0;
        done_reg   <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign quotient = zero_reg ? '0 : quo_reg;
  assign done     = done_reg;

endmodule

// File: rtl/pose_match_scorer.sv
// Per-frame overlap/union pixel counter over the truth window, followed by a
// sequential overlap*100/union score computation after the window closes.
module pose_match_scorer
  import pose_match_pkg::*;
#(
  parameter int         WIN_X        = 200,
  parameter int         WIN_Y        = 200,
  parameter int         WIN_W        = 320,
  parameter int         WIN_H        = 240,
  parameter logic [3:0] TRUTH_THRESH = 4'h8,
  parameter int         COUNT_W      = COUNT_W_DEFAULT,
  parameter int         DIV_W        = DIV_W_DEFAULT
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [11:0]        truth_pixel_in,
  input  logic               user_pixel_in,
  input  logic               enable_in,
  output logic [6:0]         score_out,
  output logic               score_valid_out,
  output logic [COUNT_W-1:0] overlap_count_out,
  output logic [COUNT_W-1:0] union_count_out,
  output logic               busy_out
);

  localparam logic [11:0] X_LO   = 12'(WIN_X);
  localparam logic [11:0] Y_LO   = 12'(WIN_Y);
  localparam logic [11:0] W_LEN  = 12'(WIN_W);
  localparam logic [11:0] H_LEN  = 12'(WIN_H);
  localparam logic [11:0] TRIG_V = 12'(WIN_Y + WIN_H);
  localparam int          ITER_W = $clog2(DIV_W);

  state_t             state_reg;
  logic [ITER_W-1:0]  iter_reg;
  logic [COUNT_W-1:0] overlap_cnt_reg;
  logic [COUNT_W-1:0] union_cnt_reg;
  logic               trig_prev_reg;

  logic [11:0]      hx;
  logic [11:0]      vy;
  logic             in_win;
  logic             truth_fg;
  logic             accumulate;
  logic             trig_raw;
  logic             trig_rise;
  logic [DIV_W-1:0] ov_ext;
  logic [DIV_W-1:0] div_dividend;
  logic [DIV_W-1:0] div_divisor;
  logic [DIV_W-1:0] div_quotient;
  logic             div_start;
  logic             div_done;
  logic [6:0]       score_next;

  always_comb begin
    hx         = {1'b0, hcount_in};
    vy         = {2'b0, vcount_in};
    in_win     = in_span(hx, X_LO, W_LEN) && in_span(vy, Y_LO, H_LEN);
    truth_fg   = (truth_pixel_in[11:8] >= TRUTH_THRESH);
    accumulate = in_win && enable_in;
    trig_raw   = (hcount_in == 11'd0) && (vy == TRIG_V);
    trig_rise  = trig_raw && !trig_prev_reg;
  end

  // overlap*100 as shifts and adds; the divider loads it on the MUL edge.
  always_comb begin
    ov_ext       = DIV_W'(overlap_count_out);
    div_dividend = (ov_ext << 6) + (ov_ext << 5) + (ov_ext << 2);
    div_divisor  = DIV_W'(union_count_out);
    div_start    = (state_reg == MUL);
  end

  always_comb begin
    score_next = '0;
    if (union_count_out != '0) begin
      score_next = (div_quotient > DIV_W'(SCORE_MAX)) ? 7'(SCORE_MAX)
                                                      : div_quotient[6:0];
    end
  end

  seq_restoring_divider #(
    .W(DIV_W)
  ) u_divider (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      iter_reg          <= '0;
      overlap_cnt_reg   <= '0;
      union_cnt_reg     <= '0;
      trig_prev_reg     <= 1'b0;
      score_out         <= '0;
      score_valid_out   <= 1'b0;
      overlap_count_out <= '0;
      union_count_out   <= '0;
      busy_out          <= 1'b0;
    end else begin
      trig_prev_reg   <= trig_raw;
      score_valid_out <= 1'b0;

      // Triggers seen while busy neither snapshot nor clear the counters.
      if (state_reg == IDLE && trig_rise) begin
        overlap_count_out <= overlap_cnt_reg;
        union_count_out   <= union_cnt_reg;
        overlap_cnt_reg   <= '0;
        union_cnt_reg     <= '0;
      end else if (accumulate) begin
        overlap_cnt_reg <= overlap_cnt_reg + COUNT_W'(truth_fg & user_pixel_in);
        union_cnt_reg   <= union_cnt_reg + COUNT_W'(truth_fg | user_pixel_in);
      end

      case (state_reg)
        IDLE: begin
          if (trig_rise) begin
            state_reg <= MUL;
            busy_out  <= 1'b1;
          end
        end
        MUL: begin
          state_reg <= DIV;
          iter_reg  <= '0;
        end
        DIV: begin
          if (iter_reg == ITER_W'(DIV_W - 1)) begin
            state_reg <= DONE;
          end else begin
            iter_reg <= iter_reg + 1'b1;
          end
        end
        DONE: begin
          score_out       <= score_next;
          score_valid_out <= div_done;
          state_reg       <= IDLE;
          busy_out        <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pose_match_scorer.sv
// Self-checking bench for pose_match_scorer on a reduced 40x20 window: table
// frames, random frames against a counting model, and busy/reset sequences.
module tb_pose_match_scorer;

  localparam int WX   = 200;
  localparam int WY   = 200;
  localparam int WW   = 40;
  localparam int WH   = 20;
  localparam int TV   = WY + WH;
  localparam int NPIX = WW * WH;
  localparam int LAT  = 26;

  localparam int M_FULL  = 0;
  localparam int M_HALF  = 1;
  localparam int M_E7FF  = 2;
  localparam int M_T800  = 3;
  localparam int M_OUT   = 4;
  localparam int M_TRUNC = 5;
  localparam int M_RAND  = 6;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [11:0] truth_pixel_in;
  logic        user_pixel_in;
  logic        enable_in;
  logic [6:0]  score_out;
  logic        score_valid_out;
  logic [16:0] overlap_count_out;
  logic [16:0] union_count_out;
  logic        busy_out;

  pose_match_scorer #(
    .WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .clk_in            (clk_in),
    .rst_n             (rst_n),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .truth_pixel_in    (truth_pixel_in),
    .user_pixel_in     (user_pixel_in),
    .enable_in         (enable_in),
    .score_out         (score_out),
    .score_valid_out   (score_valid_out),
    .overlap_count_out (overlap_count_out),
    .union_count_out   (union_count_out),
    .busy_out          (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int exp_ov   = 0;
  int exp_un   = 0;
  int snap_ov  = 0;
  int snap_un  = 0;
  int e0_cyc   = 0;

  typedef struct {
    string name;
    int    mode;
    bit    en;
    int    ov;
    int    un;
    int    sc;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit in_win(input int h, input int v);
    return (h >= WX) && (h < WX + WW) && (v >= WY) && (v < WY + WH);
  endfunction

  function automatic int ref_score(input int ov, input int un);
    return (un == 0) ? 0 : (ov * 100) / un;
  endfunction

  // Apply one pixel for one clock and fold it into the running model counts.
  task automatic drive(input int h, input int v, input int tr, input bit us, input bit en);
    bit t;
    @(negedge clk_in);
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    truth_pixel_in = 12'(tr);
    user_pixel_in  = us;
    enable_in      = en;
    t = ((tr >> 8) >= 8);
    if (in_win(h, v) && en) begin
      exp_ov += int'(t && us);
      exp_un += int'(t || us);
    end
  endtask

  task automatic park();
    drive(1, TV, 0, 1'b0, 1'b1);
  endtask

  task automatic trigger(input bit en);
    drive(0, TV, 0, 1'b0, en);
    snap_ov = exp_ov;
    snap_un = exp_un;
    exp_ov  = 0;
    exp_un  = 0;
    e0_cyc  = cyc + 1;
  endtask

  task automatic pix(input int mode, input int h, input int v, input bit en_i,
                     output int tr, output bit us, output bit en_o);
    tr = 0; us = 1'b0; en_o = en_i;
    case (mode)
      M_FULL:  begin tr = 12'hFFF; us = 1'b1; end
      M_HALF:  begin tr = (h < WX + WW / 2) ? 12'hFFF : 0; us = 1'b1; end
      M_E7FF:  begin tr = 12'h7FF; us = 1'b0; end
      M_T800:  begin tr = 12'h800; us = 1'b0; end
      M_OUT:   begin tr = in_win(h, v) ? 0 : 12'hFFF; us = !in_win(h, v); end
      M_TRUNC: begin
        if (v == WY && h == WX) begin tr = 12'hFFF; us = 1'b1; end
        if (v == WY && (h == WX + 1 || h == WX + 2)) us = 1'b1;
      end
      default: begin
        tr   = int'($urandom_range(0, 4095));
        us   = 1'($urandom_range(0, 1));
        en_o = en_i && ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic run_frame(input int mode, input bit en);
    int tr;
    bit us;
    bit e;
    for (int v = WY - 1; v <= WY + WH; v++) begin
      for (int h = WX - 2; h <= WX + WW + 1; h++) begin
        pix(mode, h, v, en, tr, us, e);
        drive(h, v, tr, us, e);
      end
    end
    trigger(en);
  endtask

  task automatic await_score(input string name, input int eov, input int eun, input int esc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      park();
      if (i == 0) chk({name, " busy_high"}, int'(busy_out), 1);
      if (score_valid_out) seen = 1'b1;
    end
    chk({name, " valid_seen"}, int'(seen), 1);
    if (seen) begin
      chk({name, " latency"}, cyc - e0_cyc, LAT);
      chk({name, " score"}, int'(score_out), esc);
      chk({name, " overlap"}, int'(overlap_count_out), eov);
      chk({name, " union"}, int'(union_count_out), eun);
      park();
      chk({name, " valid_drop"}, int'(score_valid_out), 0);
      chk({name, " busy_low"}, int'(busy_out), 0);
    end
    $display("frame %s score=%0d overlap=%0d union=%0d", name, score_out,
             overlap_count_out, union_count_out);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " score"}, int'(score_out), 0);
    chk({name, " valid"}, int'(score_valid_out), 0);
    chk({name, " overlap"}, int'(overlap_count_out), 0);
    chk({name, " union"}, int'(union_count_out), 0);
    chk({name, " busy"}, int'(busy_out), 0);
  endtask

  initial begin
    int vhits;

    tbl[0] = '{"full",       M_FULL,  1'b1, NPIX,     NPIX, 100};
    tbl[1] = '{"half",       M_HALF,  1'b1, NPIX / 2, NPIX, 50};
    tbl[2] = '{"empty_7ff",  M_E7FF,  1'b1, 0,        0,    0};
    tbl[3] = '{"thresh_800", M_T800,  1'b1, 0,        NPIX, 0};
    tbl[4] = '{"outside",    M_OUT,   1'b1, 0,        0,    0};
    tbl[5] = '{"trunc",      M_TRUNC, 1'b1, 1,        3,    33};
    tbl[6] = '{"enable_low", M_FULL,  1'b0, 0,        0,    0};

    rst_n          = 1'b0;
    hcount_in      = 11'd1;
    vcount_in      = 10'(TV);
    truth_pixel_in = '0;
    user_pixel_in  = 1'b0;
    enable_in      = 1'b1;
    repeat (3) @(negedge clk_in);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].mode, tbl[i].en);
      await_score(tbl[i].name, tbl[i].ov, tbl[i].un, tbl[i].sc);
    end

    for (int r = 0; r < 3; r++) begin
      run_frame(M_RAND, 1'b1);
      await_score("random", snap_ov, snap_un, ref_score(snap_ov, snap_un));
    end

    // Second trigger at E5 is ignored; pixels counted while busy carry over.
    run_frame(M_FULL, 1'b1);
    repeat (3) drive(WX, WY, 12'hFFF, 1'b1, 1'b1);
    park();
    drive(0, TV, 0, 1'b0, 1'b1);
    await_score("busy_retrigger", NPIX, NPIX, 100);
    run_frame(M_FULL, 1'b1);
    await_score("busy_carry", NPIX + 3, NPIX + 3, 100);

    // Reset asserted just after E10 aborts the divide with no valid pulse.
    run_frame(M_FULL, 1'b1);
    repeat (10) park();
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    exp_ov = 0;
    exp_un = 0;
    @(negedge clk_in);
    chk_zero("mid_reset");
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    vhits = 0;
    for (int i = 0; i < 40; i++) begin
      park();
      if (score_valid_out) vhits++;
    end
    chk("mid_reset no_valid", vhits, 0);
    run_frame(M_FULL, 1'b1);
    await_score("after_reset", NPIX, NPIX, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pose_match_scorer.md
Name: pose_match_scorer

Overview:
Downstream of the overlay/blend stage. Consumes the same time-aligned truth pixel and 1-bit user mask that feed the alpha blend, on the same hcount/vcount raster. Each frame it counts overlap and union pixels inside the truth-image window. After the window closes it computes an integer match score, 0-100, equal to overlap*100/union, using a sequential divider. The score feeds game scoring and the display HUD.

Parameters:
WIN_X, 200, left column of truth window
WIN_Y, 200, top row of truth window
WIN_W, 320, window width
WIN_H, 240, window height
TRUTH_THRESH, 4'h8, truth foreground if truth_pixel_in[11:8] >= this
COUNT_W, 17, pixel counter width (holds WIN_W*WIN_H = 76800)
DIV_W, 24, dividend/quotient width (holds 76800*100)

Ports:
clk_in  in  1  pixel clock
rst_n  in  1  async active-low reset
hcount_in  in  11  current pixel column
vcount_in  in  10  current pixel row
truth_pixel_in  in  12  truth greyscale pixel, aligned with hcount/vcount by caller
user_pixel_in  in  1  user mask bit, aligned by caller
enable_in  in  1  gates accumulation only
score_out  out  7  last completed score, 0..100
score_valid_out  out  1  one-cycle pulse when score_out updates
overlap_count_out  out  17  snapshot overlap count of last frame
union_count_out  out  17  snapshot union count of last frame
busy_out  out  1  high in MUL/DIV/DONE states

Behaviour:
- Interface: one clock, clk_in. Reset rst_n is asynchronous and active-low.
- Reset: all outputs 0, both counters 0, state IDLE. Reset asserted mid-operation aborts at once. No score_valid_out pulse follows for the aborted frame.
- In-window: WIN_X <= hcount_in < WIN_X+WIN_W and WIN_Y <= vcount_in < WIN_Y+WIN_H. Compare in 12-bit unsigned.
- t = (truth_pixel_in[11:8] >= TRUTH_THRESH). u = user_pixel_in.
- Accumulate every cycle where in-window and enable_in is high:
  - overlap_cnt += t&u
  - union_cnt += t|u
- Trigger: rising edge of (hcount_in==0 && vcount_in==WIN_Y+WIN_H), registered edge-detect. At most one trigger per frame.
- States: IDLE, MUL, DIV, DONE.
- E0, the edge that samples the trigger in IDLE:
  - snapshot counters into overlap_count_out and union_count_out
  - clear counters
  - go to MUL
  - the trigger pixel is outside the window, so it is never counted.
- E1 (MUL): dividend <= overlap*100, computed as (o<<6)+(o<<5)+(o<<2), DIV_W bits. Divisor <= union, zero-extended. Go to DIV; iteration counter <= 0.
- E2..E(DIV_W+1) (DIV): one restoring-division step per edge, MSB first. After the DIV_W-th step, go to DONE.
- E(DIV_W+2) (DONE):
  - score_out <= quotient[6:0], or 0 if union==0
  - score_valid_out <= 1
  - go to IDLE
- score_valid_out drops on the next edge. With defaults, valid is high in the cycle after E26.
- Quotient truncates toward zero. overlap <= union always holds, so the quotient is <= 100.
- A trigger while busy is ignored: no snapshot, counters not cleared.
- Accumulation for the new frame proceeds during MUL/DIV/DONE.
- enable_in low freezes the counters but does not block the trigger.

Decomposition:
- Package pose_match_pkg holds:
  - state enum (IDLE, MUL, DIV, DONE)
  - COUNT_W and DIV_W defaults
  - SCORE_MAX = 100
- Sub-module seq_restoring_divider:
  - ports: start, dividend, divisor, quotient, done
  - fixed DIV_W-cycle latency
  - divide-by-zero returns quotient 0
- The scorer owns the counters, trigger detection and the FSM.

Test Plan:
- Full overlap: truth 12'hFFF and user 1 over the whole window. Expect overlap=76800, union=76800, score 100, valid pulse exactly 26 cycles after the trigger edge.
- Half overlap: user 1 over the whole window; truth 12'hFFF only for columns 200..359. Expect overlap=38400, union=76800, score 50.
- Empty or threshold: truth 12'h7FF everywhere, user 0. Expect union 0, score 0, valid still pulses. Then truth 12'h800 everywhere, user 0. Expect union 76800, score 0.
- Window exclusion and truncation: user 1 and truth 12'hFFF outside the window only. Expect counts 0. Then in-window one t&u pixel plus two u-only pixels. Expect overlap 1, union 3, score 33.
- Reset mid-divide: drop rst_n at E10 for 3 cycles. Expect all outputs 0 and no valid pulse. The next full frame of full-overlap stimulus gives score 100.
- Busy and enable: second trigger injected at E5 is ignored, counts unchanged. With enable_in low for whole frame, expect counts 0 and score 0.
